// File: rtl/pool_pkg.sv
// pool_pkg: shared mode encoding and depth/width helpers for the pool reduction tree
package pool_pkg;
  typedef enum logic {MODE_SUM = 1'b0, MODE_MAX = 1'b1} pool_mode_e;
  function automatic int levels(input int n_lanes);
    return $clog2(n_lanes);
  endfunction
  function automatic int stage_wid(input int wid_in, input int k);
    return wid_in + k;
  endfunction
endpackage

// File: rtl/pool_reduce_stage.sv
// pool_reduce_stage: one pairwise combine level with valid/mode/count registers (POOL_TREE_MAX_EN adds MAX)
module pool_reduce_stage
  import pool_pkg::*;
#(
  parameter int N_LANE = 32,
  parameter int WID = 16,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic adv_i,
  input  logic valid_i,
`ifdef POOL_TREE_MAX_EN
  input  logic mode_i,
  output logic mode_o,
`endif
  input  logic [CNT_W-1:0] count_i,
  input  logic [N_LANE*WID-1:0] data_i,
  output logic valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic [(N_LANE/2)*(WID+1)-1:0] data_o
);
  localparam int M = N_LANE / 2;
  localparam int WO = WID + 1;
  logic [M*WO-1:0] data_d, data_q;
  logic valid_q;
  logic [CNT_W-1:0] count_q;
`ifdef POOL_TREE_MAX_EN
  logic mode_q;
`endif
  for (genvar j = 0; j < M; j++) begin : g_pair
    logic signed [WID:0] a, b;
    assign a = $signed(data_i[2*j*WID +: WID]);
    assign b = $signed(data_i[(2*j+1)*WID +: WID]);
`ifdef POOL_TREE_MAX_EN
    assign data_d[j*WO +: WO] = (mode_i == MODE_MAX) ? ((a > b) ? a : b) : a + b;
`else
    assign data_d[j*WO +: WO] = a + b;
`endif
  end
  // stage registers advance together under the global enable; bubbles pass through as valid=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
`ifdef POOL_TREE_MAX_EN
      mode_q  <= 1'b0;
`endif
    end else if (adv_i) begin
      data_q  <= data_d;
      valid_q <= valid_i;
      count_q <= count_i;
`ifdef POOL_TREE_MAX_EN
      mode_q  <= mode_i;
`endif
    end
  end
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;
`ifdef POOL_TREE_MAX_EN
  assign mode_o  = mode_q;
`endif
endmodule

// File: rtl/pool_reduce_tree.sv
// pool_reduce_tree: pipelined masked signed SUM reduction with valid/ready (POOL_TREE_MAX_EN adds per-beat MAX mode)
module pool_reduce_tree
  import pool_pkg::*;
#(
  parameter int N_IN = 32,
  parameter int WID_IN = 16,
  parameter int WID_OUT = WID_IN + $clog2(N_IN)
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_IN*WID_IN-1:0] in_data,
  input  logic [N_IN-1:0] in_mask,
`ifdef POOL_TREE_MAX_EN
  input  logic in_mode,
`endif
  output logic out_valid,
  input  logic out_ready,
  output logic [WID_OUT-1:0] out_data,
  output logic [$clog2(N_IN):0] out_count
);
  localparam int L = levels(N_IN);
  localparam int CW = L + 1;
  logic adv;
  logic [WID_IN-1:0] fill;
  logic [N_IN*WID_IN-1:0] clean;
  logic [CW-1:0] pop;
  logic signed [WID_OUT-1:0] ext;
  assign adv = out_ready || !out_valid;
  assign in_ready = adv;
`ifdef POOL_TREE_MAX_EN
  assign fill = (in_mode == MODE_MAX) ? {1'b1, {(WID_IN-1){1'b0}}} : '0;
`else
  assign fill = '0;
`endif
  // masked-out lanes are replaced by the identity of the active operation
  always_comb begin
    clean = '0;
    for (int i = 0; i < N_IN; i++) clean[i*WID_IN +: WID_IN] = in_mask[i] ? in_data[i*WID_IN +: WID_IN] : fill;
  end
  // active-lane count travels with the beat for downstream averaging
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_IN; i++) pop = pop + CW'(in_mask[i]);
  end
  for (genvar k = 0; k < L; k++) begin : g_st
    localparam int NI = N_IN >> k;
    localparam int WI = stage_wid(WID_IN, k);
    logic [NI*WI-1:0] d_in;
    logic [(NI/2)*(WI+1)-1:0] d_out;
    logic v_in, v_out;
    logic [CW-1:0] c_in, c_out;
`ifdef POOL_TREE_MAX_EN
    logic m_in, m_out;
`endif
    if (k == 0) begin : g_first
      assign d_in = clean;
      assign v_in = in_valid;
      assign c_in = pop;
`ifdef POOL_TREE_MAX_EN
      assign m_in = in_mode;
`endif
    end else begin : g_next
      assign d_in = g_st[k-1].d_out;
      assign v_in = g_st[k-1].v_out;
      assign c_in = g_st[k-1].c_out;
`ifdef POOL_TREE_MAX_EN
      assign m_in = g_st[k-1].m_out;
`endif
    end
    pool_reduce_stage #(.N_LANE(NI), .WID(WI), .CNT_W(CW)) u_stage (
      .clk(clk),
      .rst(rst),
      .adv_i(adv),
      .valid_i(v_in),
`ifdef POOL_TREE_MAX_EN
      .mode_i(m_in),
      .mode_o(m_out),
`endif
      .count_i(c_in),
      .data_i(d_in),
      .valid_o(v_out),
      .count_o(c_out),
      .data_o(d_out)
    );
  end
`ifdef POOL_TREE_MAX_EN
  logic unused_mode;
  assign unused_mode = g_st[L-1].m_out;
`endif
  assign ext = $signed(g_st[L-1].d_out);
  assign out_valid = g_st[L-1].v_out;
  assign out_count = g_st[L-1].c_out;
  assign out_data = (g_st[L-1].c_out == '0) ? '0 : ext;
endmodule

// File: tb/tb_pool_reduce_tree.sv
// tb_pool_reduce_tree: scoreboard bench for pool_reduce_tree at N_IN=32, WID_IN=16 (MAX tests under POOL_TREE_MAX_EN)
module tb_pool_reduce_tree;
  typedef struct packed {logic [20:0] d; logic [5:0] c;} exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, in_mode;
  logic [511:0] in_data;
  logic [31:0] in_mask;
  logic [20:0] out_data;
  logic [5:0] out_count;
  int pass_cnt = 0, total_cnt = 0;
  exp_t q[$];

  pool_reduce_tree #(.N_IN(32), .WID_IN(16), .WID_OUT(21)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_mask(in_mask),
`ifdef POOL_TREE_MAX_EN
    .in_mode(in_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [511:0] d, input logic [31:0] m, input logic md);
    longint s = 0, mx = -32768, res;
    int c = 0;
    shortint v;
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      v = d[i*16 +: 16];
      if (m[i]) begin
        c++;
        s += v;
        if (v > mx) mx = v;
      end
    end
    res = (c == 0) ? 0 : (md ? mx : s);
    e.d = 21'(res);
    e.c = 6'(c);
    return e;
  endfunction

  function automatic logic [511:0] fill(input logic [15:0] v);
    logic [511:0] r;
    for (int i = 0; i < 32; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  always begin
    @(negedge clk);
    #4;
    if (!rst && out_valid && out_ready) begin
      total_cnt++;
      if (q.size() == 0) begin
        $display("FAIL sb_unexpected: got data=%0d count=%0d, required no output", $signed(out_data), out_count);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({out_data, out_count} !== {e.d, e.c})
          $display("FAIL sb_result: got data=%0d count=%0d, required data=%0d count=%0d",
                   $signed(out_data), out_count, $signed(e.d), e.c);
        else pass_cnt++;
      end
    end
  end

  task automatic drive(input logic [511:0] d, input logic [31:0] m, input logic md);
    int t;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_mask = m;
`ifdef POOL_TREE_MAX_EN
    in_mode = md;
    e = model(d, m, md);
`else
    in_mode = 1'b0;
    e = model(d, m, 1'b0);
`endif
    for (t = 0; t < 200; t++) begin
      #4;
      if (in_ready) break;
      @(negedge clk);
    end
    if (t == 200) begin
      total_cnt++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 200 cycles, required 1");
      in_valid = 1'b0;
    end else begin
      q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    for (t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (q.size() != 0) $display("FAIL %s_drain: %0d results pending, required 0", name, q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_mask = '0;
    in_mode = 1'b0;
    out_ready = 1'b0;
    #12;
    total_cnt += 4;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", out_valid); else pass_cnt++;
    if (out_data !== 21'd0) $display("FAIL reset_data: got %0d, required 0", out_data); else pass_cnt++;
    if (out_count !== 6'd0) $display("FAIL reset_count: got %0d, required 0", out_count); else pass_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", in_ready); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_sum_basic();
    int n;
    drive(fill(16'd1), 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (1) begin
      #4;
      if (out_valid || n >= 20) break;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    total_cnt++;
    if (n != 5) $display("FAIL latency: got %0d cycles, required 5", n); else pass_cnt++;
    wait_drain("sum_basic");
  endtask

  task automatic test_sign_range();
    logic [511:0] d;
    drive(fill(16'hFFFF), 32'hFFFF_FFFF, 1'b0);
    drive(fill(16'd32767), 32'hFFFF_FFFF, 1'b0);
    d = fill(16'd1000);
    d[15:0] = 16'd5;
    d[511:496] = 16'd7;
    drive(d, 32'h8000_0001, 1'b0);
    drive(fill(16'h8000), 32'hFFFF_FFFF, 1'b0);
    drive(fill(16'd77), 32'h0, 1'b0);
    idle();
    wait_drain("sign_range");
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int n = 1; n <= 8; n++) drive(fill(16'(n)), 32'hFFFF_FFFF, 1'b0);
        idle();
      end
      begin
        repeat (7) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) begin
          #4;
          total_cnt += 2;
          if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL stall_handshake: got in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
          else pass_cnt++;
          if (q.size() == 0 || {out_data, out_count} !== {q[0].d, q[0].c})
            $display("FAIL stall_hold: got data=%0d count=%0d, required held head of queue", $signed(out_data), out_count);
          else pass_cnt++;
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("back_to_back");
  endtask

`ifdef POOL_TREE_MAX_EN
  task automatic test_max();
    logic [511:0] d;
    for (int i = 0; i < 32; i++) d[i*16 +: 16] = 16'(i - 16);
    drive(d, 32'h7FFF_FFFF, 1'b1);
    drive(d, 32'h0, 1'b1);
    drive(fill(16'd3), 32'hFFFF_FFFF, 1'b0);
    drive(d, 32'hFFFF_FFFF, 1'b1);
    drive(d, 32'hFFFF_FFFF, 1'b0);
    drive(fill(16'h8001), 32'h0000_0010, 1'b1);
    idle();
    wait_drain("max");
  endtask
`endif

  task automatic test_random();
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          logic [511:0] d;
          for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
          drive(d, $urandom, 1'($urandom_range(0, 1)));
        end
        idle();
      end
      begin
        repeat (30) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
  endtask

  task automatic test_async_reset();
    int seen = 0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(fill(16'd2), 32'hFFFF_FFFF, 1'b0);
    drive(fill(16'd3), 32'hFFFF_FFFF, 1'b0);
    drive(fill(16'd4), 32'hFFFF_FFFF, 1'b0);
    idle();
    repeat (6) @(negedge clk);
    #4;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL areset_pre: got out_valid=%b, required 1", out_valid); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid, out_data, out_count} !== 28'd0)
      $display("FAIL areset_drop: got valid=%b data=%0d count=%0d, required all 0", out_valid, out_data, out_count);
    else pass_cnt++;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) begin
      #4;
      if (out_valid) seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (seen != 0) $display("FAIL areset_stale: got %0d valid cycles, required 0", seen); else pass_cnt++;
    drive(fill(16'd9), 32'h0000_FFFF, 1'b0);
    idle();
    wait_drain("areset_new");
  endtask

  initial begin
    test_reset();
    test_sum_basic();
    test_sign_range();
    test_back_to_back();
`ifdef POOL_TREE_MAX_EN
    test_max();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
